// File: rtl/digit_entry_buffer.sv
// digit_entry_buffer
// Keypad digit-entry buffer. It collects BCD digits into a DIGITS-deep
// nibble shift register and supports backspace, sign toggle and clear.
// On commit it converts the entry to a two's-complement operand, one digit
// per cycle, and then holds the result on a valid/ready handshake.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   digit_valid  strobe, digit carries a new key
//   digit        BCD key value (0-9 legal)
//   backspace    strobe, drop the last entered digit
//   neg_toggle   strobe, invert the entry sign
//   clear        strobe, discard the entry or abort a conversion
//   commit       strobe, start the conversion
//   bcd_value    entered digits, last digit in [3:0]
//   count        number of digits entered
//   negative     entry sign
//   full         count == DIGITS
//   err          one-cycle pulse, digit rejected
//   busy         converting or holding a result
//   out_valid    out_data holds a committed operand
//   out_data     two's-complement committed operand
//   out_ready    consumer accepts out_data
//
// state   | meaning
// ENTRY   | edits accepted, entry displayed
// CONVERT | acc built one digit per cycle, entry frozen
// HOLD    | out_valid high, waiting for out_ready
module digit_entry_buffer #(
  parameter int DIGITS = 10,
  parameter int OUT_W  = 35
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         digit_valid,
  input  logic [3:0]                   digit,
  input  logic                         backspace,
  input  logic                         neg_toggle,
  input  logic                         clear,
  input  logic                         commit,
  output logic [4*DIGITS-1:0]          bcd_value,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic                         negative,
  output logic                         full,
  output logic                         err,
  output logic                         busy,
  output logic                         out_valid,
  output logic [OUT_W-1:0]             out_data,
  input  logic                         out_ready
);

  localparam int CW = $clog2(DIGITS+1);
  localparam int BW = 4*DIGITS;

  typedef enum logic [1:0] {ENTRY, CONVERT, HOLD} state_t;

  state_t           state, state_nxt;
  logic [OUT_W-1:0] acc;
  logic [CW-1:0]    step;        // digits still to fold into acc
  logic [CW-1:0]    step_m1;
  logic [BW-1:0]    shifted;
  logic [3:0]       nib;

  // step counts down from DIGITS, so step-1 is the nibble position to consume
  always_comb begin
    step_m1 = step - CW'(1);
    shifted = bcd_value >> {step_m1, 2'b00};
    nib     = shifted[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ENTRY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ENTRY:   if (!clear && commit) state_nxt = CONVERT;
      CONVERT: if (clear) state_nxt = ENTRY;
               else if (step == '0) state_nxt = HOLD;
      HOLD:    if (clear || out_ready) state_nxt = ENTRY;
      default: state_nxt = ENTRY;
    endcase
  end

  always_comb begin
    busy      = (state != ENTRY);
    out_valid = (state == HOLD);
    full      = (count == CW'(DIGITS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_value <= '0;
      count     <= '0;
      negative  <= 1'b0;
      err       <= 1'b0;
      out_data  <= '0;
      acc       <= '0;
      step      <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        ENTRY: begin
          if (clear) begin
            bcd_value <= '0;
            count     <= '0;
            negative  <= 1'b0;
          end else if (commit) begin
            acc  <= '0;
            step <= CW'(DIGITS);
          end else begin
            if (neg_toggle) negative <= ~negative;
            if (backspace) begin
              if (count != '0) begin
                bcd_value <= bcd_value >> 4;
                count     <= count - CW'(1);
              end
            end else if (digit_valid) begin
              if (digit > 4'd9 || full) begin
                err <= 1'b1;
              end else begin
                bcd_value <= (bcd_value << 4) | BW'(digit);
                count     <= count + CW'(1);
              end
            end
          end
        end
        CONVERT: begin
          if (clear) begin
            bcd_value <= '0;
            count     <= '0;
            negative  <= 1'b0;
          end else if (step != '0) begin
            acc  <= (acc << 3) + (acc << 1) + OUT_W'(nib);
            step <= step_m1;
          end else begin
            // -0 wraps to 0, so negative zero needs no special case
            out_data <= negative ? -acc : acc;
          end
        end
        HOLD: begin
          if (clear || out_ready) begin
            bcd_value <= '0;
            count     <= '0;
            negative  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_entry_buffer.sv
`timescale 1ns/1ps
module tb_digit_entry_buffer;

  localparam int DIGITS = 10;
  localparam int OUT_W  = 35;

  logic              clk = 1'b0;
  logic              rst;
  logic              digit_valid, backspace, neg_toggle, clear, commit, out_ready;
  logic [3:0]        digit;
  logic [39:0]       bcd_value;
  logic [3:0]        count;
  logic              negative, full, err, busy, out_valid;
  logic [OUT_W-1:0]  out_data;

  int total = 0;
  int bad   = 0;

  digit_entry_buffer #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
    .backspace(backspace), .neg_toggle(neg_toggle), .clear(clear),
    .commit(commit), .bcd_value(bcd_value), .count(count),
    .negative(negative), .full(full), .err(err), .busy(busy),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [3:0]  dg;
    logic        bs;
    logic        ng;
    logic        cl;
    logic [39:0] e_bcd;
    logic [3:0]  e_cnt;
    logic        e_neg;
    logic        e_err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    digit_valid = 0; digit = 0; backspace = 0; neg_toggle = 0;
    clear = 0; commit = 0;
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1; digit = d;
    cyc();
    idle();
  endtask

  task automatic pulse_commit();
    commit = 1;
    cyc();
    idle();
  endtask

  task automatic pulse_clear();
    clear = 1;
    cyc();
    idle();
  endtask

  // counts edges after the commit edge until out_valid is seen
  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (out_valid) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      bad++; total++;
      $display("FAIL wait_valid: out_valid never rose within 40 cycles");
    end
  endtask

  initial begin
    int n;
    idle();
    out_ready = 0;
    rst = 1;
    vecs[0]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 40'h1,   4'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 40'h12,  4'd2, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 40'h123, 4'd3, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 40'h123, 4'd3, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 40'h123, 4'd3, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 40'h12,  4'd2, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 40'h1,   4'd1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 40'h1,   4'd1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 40'h0,   4'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 40'h0,   4'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 40'h0,   4'd1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 4'h4, 1'b0, 1'b1, 1'b0, 40'h4,   4'd2, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 40'h0,   4'd0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_state", {bcd_value, count, negative, full, err, busy, out_valid},
        {40'h0, 4'd0, 5'b0});
    chk("reset_out_data", 64'(out_data), 64'h0);

    // editing table
    for (int i = 0; i < 13; i++) begin
      digit_valid = vecs[i].dv; digit = vecs[i].dg; backspace = vecs[i].bs;
      neg_toggle = vecs[i].ng; clear = vecs[i].cl;
      cyc();
      idle();
      chk($sformatf("vec%0d", i), {bcd_value, count, negative, err, busy},
          {vecs[i].e_bcd, vecs[i].e_cnt, vecs[i].e_neg, vecs[i].e_err, 1'b0});
    end

    // 1,2,3 commit with out_ready already high
    key(1); key(2); key(3);
    out_ready = 1;
    pulse_commit();
    chk("commit_busy", {busy, out_valid, bcd_value, count}, {1'b1, 1'b0, 40'h123, 4'd3});
    wait_valid(n);
    chk("latency", 64'(n), 64'd11);
    chk("data_123", 64'(out_data), 64'd123);
    cyc();
    chk("handshake_clear", {out_valid, busy, bcd_value, count}, {2'b00, 40'h0, 4'd0});
    out_ready = 0;

    // full entry and overflow digit
    for (int i = 0; i < 10; i++) key(9);
    chk("full_set", {full, count, bcd_value}, {1'b1, 4'd10, 40'h9999999999});
    key(5);
    chk("full_reject", {err, full, bcd_value}, {2'b11, 40'h9999999999});
    cyc();
    chk("err_one_cycle", 64'(err), 64'h0);
    pulse_commit();
    wait_valid(n);
    chk("data_max", 64'(out_data), 64'h2540BE3FF);
    out_ready = 1; cyc(); out_ready = 0;
    chk("max_cleared", {out_valid, count}, {1'b0, 4'd0});

    // backspace with sign toggle, negative result
    key(4); key(5);
    backspace = 1; neg_toggle = 1; cyc(); idle();
    chk("bs_neg", {count, negative, bcd_value}, {4'd1, 1'b1, 40'h4});
    pulse_commit();
    wait_valid(n);
    chk("data_neg4", 64'(out_data), 64'h7FFFFFFFC);
    out_ready = 1; cyc(); out_ready = 0;
    chk("neg_cleared", {negative, count}, {1'b0, 4'd0});

    // negative zero
    neg_toggle = 1; cyc(); idle();
    chk("neg_empty", {negative, count}, {1'b1, 4'd0});
    pulse_commit();
    wait_valid(n);
    chk("data_negzero", 64'(out_data), 64'h0);
    out_ready = 1; cyc(); out_ready = 0;

    // hold with back-pressure, ignored strobes, then abort
    key(4); key(2);
    pulse_commit();
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      digit_valid = 1; digit = 4'(i); backspace = (i == 2); neg_toggle = (i == 3);
      cyc();
      idle();
      chk($sformatf("hold%0d", i), {out_valid, err, negative, count, bcd_value, 64'(out_data)},
          {1'b1, 1'b0, 1'b0, 4'd2, 40'h42, 64'd42});
    end
    pulse_clear();
    chk("hold_abort", {out_valid, busy, count, bcd_value}, {2'b00, 4'd0, 40'h0});

    // reset during conversion
    key(7); key(7);
    pulse_commit();
    cyc(); cyc();
    #2 rst = 1;
    #1;
    chk("async_reset", {bcd_value, count, negative, full, err, busy, out_valid, 64'(out_data)},
        {40'h0, 4'd0, 5'b0, 64'h0});
    @(negedge clk);
    rst = 0;
    key(3);
    chk("after_reset", {bcd_value, count, busy}, {40'h3, 4'd1, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
